agc_alu_seq: RTL

- Sequenced arithmetic unit for the Apollo Guidance Computer build.
- It is the responder side of the alu_op interface driven by the control-pulse FSM. It accepts an opcode plus X/Y operands on a start strobe, executes the operation, and returns a registered result with a one-cycle done pulse.
- AD, SU and MASK complete in fixed short latency. MP and DV run iterative shift-add and restoring-divide sequences and hold their second-half result for a following MP1/DV1 read.

---
 rtl/agc_alu_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/agc_alu_seq.sv
// Sequenced ones' complement arithmetic unit: single-cycle AD/SU/MASK plus
// 15-step shift-add multiply and restoring divide with a stored second half.
module agc_alu_seq #(
  parameter int WIDTH = 16,
  parameter int ITER  = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             div_zero
);

  // Handshake: a request is accepted on a rising edge where start=1 and the
  // unit is idle with no done pulse showing; done is a one-cycle pulse and
  // result/ovf/div_zero are valid while it is high.

  localparam logic [2:0] OP_AD  = 3'd0;
  localparam logic [2:0] OP_SU  = 3'd1;
  localparam logic [2:0] OP_MASK = 3'd2;
  localparam logic [2:0] OP_MP0 = 3'd3;
  localparam logic [2:0] OP_MP1 = 3'd4;
  localparam logic [2:0] OP_DV0 = 3'd5;
  localparam logic [2:0] OP_DV1 = 3'd6;

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_ITER, S_FINAL, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [15:0] x_q, y_q;
  logic [2:0]  op_q;
  logic [3:0]  cnt;
  logic [14:0] acc;        // product high half / partial remainder
  logic [14:0] mq;         // multiplier, product low half / dividend, quotient
  logic [15:0] res_stage, hold_stage, hold_q;
  logic        ovf_stage, dz_stage;
  logic        accept;

  function automatic logic [14:0] mag(input logic [15:0] v);
    return v[15] ? ~v[14:0] : v[14:0];
  endfunction

  function automatic logic [15:0] enc(input logic s, input logic [14:0] m);
    if (m == 15'd0) return 16'h0000;
    return s ? {1'b1, ~m} : {1'b0, m};
  endfunction

  logic [14:0] mag_x, mag_y;
  logic [15:0] y_add, add_res, mp_sum, dv_sh;
  logic [16:0] s17, dv_diff;

  assign mag_x   = mag(x_q);
  assign mag_y   = mag(y_q);
  assign y_add   = (op_q == OP_SU) ? ~y_q : y_q;
  assign s17     = {1'b0, x_q} + {1'b0, y_add};
  assign add_res = s17[15:0] + {15'd0, s17[16]};
  assign mp_sum  = {1'b0, acc} + (mq[0] ? {1'b0, mag_x} : 16'd0);
  assign dv_sh   = {acc, mq[14]};
  assign dv_diff = {1'b0, dv_sh} - {2'b00, mag_y};

  assign accept = start && (state == S_IDLE) && !done;
  assign busy   = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = (alu_op == OP_MP0 || alu_op == OP_DV0) ? S_ITER : S_EXEC;
      S_EXEC:  state_nxt = S_DONE;
      S_ITER:  if (cnt == 4'd1) state_nxt = S_FINAL;
      S_FINAL: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0; y_q <= '0; op_q <= '0; cnt <= '0;
      acc <= '0; mq <= '0;
      res_stage <= '0; hold_stage <= '0; hold_q <= '0;
      ovf_stage <= 1'b0; dz_stage <= 1'b0;
      result <= '0; ovf <= 1'b0; div_zero <= 1'b0; done <= 1'b0;
    end else begin
      done <= (state == S_DONE);
      case (state)
        S_IDLE: if (accept) begin
          x_q  <= x;
          y_q  <= y;
          op_q <= alu_op;
          cnt  <= 4'(ITER);
          acc  <= '0;
          mq   <= (alu_op == OP_MP0) ? mag(y) : mag(x);
        end
        S_EXEC: begin
          ovf_stage <= 1'b0;
          case (op_q)
            OP_AD, OP_SU: begin
              res_stage <= add_res;
              ovf_stage <= add_res[15] ^ add_res[14];
            end
            OP_MASK:        res_stage <= x_q & y_q;
            OP_MP1, OP_DV1: res_stage <= hold_q;
            default:        res_stage <= '0;
          endcase
        end
        S_ITER: begin
          cnt <= cnt - 4'd1;
          if (op_q == OP_MP0) begin
            acc <= mp_sum[15:1];
            mq  <= {mp_sum[0], mq[14:1]};
          end else begin
            acc <= dv_diff[16] ? dv_sh[14:0] : dv_diff[14:0];
            mq  <= {mq[13:0], ~dv_diff[16]};
          end
        end
        S_FINAL: begin
          ovf_stage <= 1'b0;
          if (op_q == OP_MP0) begin
            res_stage  <= enc(x_q[15] ^ y_q[15], mq);
            hold_stage <= enc(x_q[15] ^ y_q[15], acc);
          end else if (mag_y == 15'd0) begin
            res_stage  <= enc(x_q[15], mag_x);
            hold_stage <= enc(x_q[15] ^ y_q[15], 15'h7FFF);
            dz_stage   <= 1'b1;
          end else begin
            res_stage  <= enc(x_q[15], acc);
            hold_stage <= enc(x_q[15] ^ y_q[15], mq);
            dz_stage   <= 1'b0;
          end
        end
        S_DONE: begin
          result <= res_stage;
          ovf    <= ovf_stage;
          if (op_q == OP_DV0) div_zero <= dz_stage;
          if (op_q == OP_MP0 || op_q == OP_DV0) hold_q <= hold_stage;
        end
        default: ;
      endcase
    end
  end

endmodule
